// File: rtl/arm_multicycle_datapath.sv
// arm_multicycle_datapath: multicycle ARM datapath sharing one ALU and one memory port across cycles
module arm_multicycle_datapath #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit REG_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        AdrSrc,
  input  logic        IRWrite,
  input  logic [1:0]  RegSrc,
  input  logic        RegWrite,
  input  logic [1:0]  ImmSrc,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ALUControl,
  input  logic [1:0]  ResultSrc,
  input  logic [31:0] ReadData,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic [31:0] Instr,
  output logic [3:0]  ALUFlags
);
  logic [31:0] pc, data, a, aluout;
  logic [31:0] rf [0:14];
  logic [3:0]  ra1, ra2;
  logic [31:0] rd1, rd2, ext, srca, srcb, bx, aluresult, result;
  logic [32:0] sum;
  logic        we;
  always_comb begin
    ra1 = RegSrc[0] ? 4'd15 : Instr[19:16];
    ra2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];
    ext = ImmSrc == 2'b00 ? {24'b0, Instr[7:0]} :
          ImmSrc == 2'b01 ? {20'b0, Instr[11:0]} :
          ImmSrc == 2'b10 ? {{6{Instr[23]}}, Instr[23:0], 2'b00} : '0;
    srca = ALUSrcA ? pc : a;
    srcb = ALUSrcB[1] ? 32'd4 : ALUSrcB[0] ? ext : WriteData;
    bx = ALUControl[0] ? ~srcb : srcb;
    sum = {1'b0, srca} + {1'b0, bx} + {32'b0, ALUControl[0]};
    aluresult = ALUControl[1] ? (ALUControl[0] ? srca | srcb : srca & srcb) : sum[31:0];
    ALUFlags = {aluresult[31], aluresult == '0, ~ALUControl[1] & sum[32],
                ~ALUControl[1] & (srca[31] == bx[31]) & (sum[31] != srca[31])};
    result = ResultSrc == 2'b00 ? aluout : ResultSrc == 2'b01 ? data : aluresult;
    Adr = AdrSrc ? result : pc;
    // R15 reads return Result, which is PC+8 during decode
    rd1 = ra1 == 4'd15 ? result : rf[ra1];
    rd2 = ra2 == 4'd15 ? result : rf[ra2];
    we = RegWrite && Instr[15:12] != 4'd15;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_VECTOR;
      Instr <= '0;
      data <= '0;
      a <= '0;
      WriteData <= '0;
      aluout <= '0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite) Instr <= ReadData;
      data <= ReadData;
      a <= rd1;
      WriteData <= rd2;
      aluout <= aluresult;
    end
  generate
    if (REG_CLEAR) begin : g_clr
      always_ff @(posedge clk or posedge reset)
        if (reset) for (int i = 0; i < 15; i++) rf[i] <= '0;
        else if (we) rf[Instr[15:12]] <= result;
    end else begin : g_keep
      always_ff @(posedge clk)
        if (!reset && we) rf[Instr[15:12]] <= result;
    end
  endgenerate
endmodule

// File: tb/tb_arm_multicycle_datapath.sv
// tb_arm_multicycle_datapath: drives controller sequences and scoreboards outputs against an ISA-level model
module tb_arm_multicycle_datapath;
  localparam logic [31:0] RV = 32'h100;
  logic clk = 0, reset = 1;
  logic PCWrite, AdrSrc, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
  logic [31:0] ReadData, Adr, WriteData, Instr;
  logic [3:0] ALUFlags;
  arm_multicycle_datapath #(.RESET_VECTOR(RV), .REG_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .ReadData(ReadData), .Adr(Adr), .WriteData(WriteData), .Instr(Instr), .ALUFlags(ALUFlags));
  always #5 clk = ~clk;
  typedef struct { int cyc; int kind; logic [31:0] val; } exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic done = 0, mon_done = 0;
  logic [31:0] regs [0:14];
  logic [31:0] pc, fpc;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] got(int k);
    return k == 0 ? Adr : k == 1 ? WriteData : k == 2 ? Instr : {28'b0, ALUFlags};
  endfunction
  function automatic string nm(int k);
    return k == 0 ? "Adr" : k == 1 ? "WriteData" : k == 2 ? "Instr" : "ALUFlags";
  endfunction
  always @(negedge clk) begin : mon
    exp_t e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = got(e.kind);
      n_chk++;
      if (e.cyc != cyc || act !== e.val) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", nm(e.kind), e.cyc, act, e.val);
      end
    end
    if (done && !mon_done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL %s never observed (cycle %0d): expected %h", nm(e.kind), e.cyc, e.val);
      end
      mon_done = 1;
    end
  end
  task automatic want(input int kind, input logic [31:0] v);
    q.push_back('{cyc, kind, v});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic pcw, adrs, irw, input logic [1:0] rs, input logic rw,
                       input logic [1:0] imm, input logic sa, input logic [1:0] sb, op, res);
    PCWrite = pcw; AdrSrc = adrs; IRWrite = irw; RegSrc = rs; RegWrite = rw;
    ImmSrc = imm; ALUSrcA = sa; ALUSrcB = sb; ALUControl = op; ResultSrc = res;
  endtask
  function automatic logic [31:0] rv(input logic [3:0] r);
    return r == 4'd15 ? fpc + 32'd8 : regs[r];
  endfunction
  // ISA-level ALU: returns {N,Z,C,V,result}
  function automatic logic [35:0] alu(input logic [1:0] op, input logic [31:0] x, y);
    logic [31:0] r;
    logic c, v;
    longint sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    c = 0; v = 0;
    if (op == 0) begin
      r = x + y; c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF; s = sx + sy;
      v = s > 64'sd2147483647 || s < -64'sd2147483648;
    end else if (op == 1) begin
      r = x - y; c = x >= y; s = sx - sy;
      v = s > 64'sd2147483647 || s < -64'sd2147483648;
    end else r = op == 2 ? (x & y) : (x | y);
    return {r[31], r == 0, c, v, r};
  endfunction
  task automatic fetch(input logic [31:0] w);
    fpc = pc;
    drive(1, 0, 1, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 2'b10);
    ReadData = w;
    want(0, pc);
    tick;
    pc = pc + 4;
  endtask
  task automatic decode(input logic [31:0] w, input logic [1:0] rs);
    drive(0, 0, 0, rs, 0, 2'b00, 1, 2'b10, 2'b00, 2'b10);
    ReadData = $urandom;
    want(2, w);
    tick;
  endtask
  task automatic dp(input logic imm, input logic [1:0] op, input logic [31:0] w);
    logic [35:0] r;
    fetch(w);
    r = alu(op, rv(w[19:16]), imm ? {24'b0, w[7:0]} : rv(w[3:0]));
    decode(w, 2'b00);
    drive(0, 0, 0, 2'b00, 0, 2'b00, 0, imm ? 2'b01 : 2'b00, op, 2'b10);
    want(3, {28'b0, r[35:32]});
    tick;
    drive(0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    tick;
    if (w[15:12] != 15) regs[w[15:12]] = r[31:0];
  endtask
  task automatic ldr(input logic [31:0] w, input logic [31:0] d);
    logic [31:0] ea;
    fetch(w);
    ea = rv(w[19:16]) + {20'b0, w[11:0]};
    decode(w, 2'b00);
    drive(0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b01, 2'b00, 2'b10);
    tick;
    drive(0, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    ReadData = d;
    want(0, ea);
    tick;
    drive(0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 2'b00, 2'b01);
    ReadData = $urandom;
    tick;
    if (w[15:12] != 15) regs[w[15:12]] = d;
  endtask
  task automatic str(input logic [31:0] w);
    logic [31:0] ea;
    fetch(w);
    ea = rv(w[19:16]) + {20'b0, w[11:0]};
    decode(w, 2'b10);
    drive(0, 0, 0, 2'b10, 0, 2'b01, 0, 2'b01, 2'b00, 2'b10);
    tick;
    drive(0, 1, 0, 2'b10, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    want(0, ea);
    want(1, regs[w[15:12]]);
    tick;
  endtask
  task automatic br(input logic [31:0] w);
    fetch(w);
    decode(w, 2'b01);
    drive(1, 0, 0, 2'b00, 0, 2'b10, 0, 2'b01, 2'b00, 2'b10);
    tick;
    pc = fpc + 32'd8 + ({{8{w[23]}}, w[23:0]} << 2);
  endtask
  task automatic model_reset;
    pc = RV;
    for (int i = 0; i < 15; i++) regs[i] = '0;
  endtask
  task automatic rst_mid(input logic [31:0] w);
    fetch(w);
    decode(w, 2'b00);
    drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 2'b00, 2'b10);
    #2 reset = 1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    model_reset;
    want(0, RV);
    want(1, 32'h0);
    want(2, 32'h0);
    tick;
    reset = 0;
  endtask
  initial begin
    logic [31:0] w;
    drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    ReadData = '0;
    model_reset;
    tick;
    want(0, RV);
    want(1, 32'h0);
    want(2, 32'h0);
    tick;
    reset = 0;
    dp(1, 2'd0, 32'hE280_1005);
    ldr(32'hE591_2008, 32'hDEAD_BEEF);
    br(32'hEAFF_FFFE);
    str(32'hE581_2000);
    ldr(32'hE590_3000, 32'h7FFF_FFFF);
    ldr(32'hE590_4000, 32'hFFFF_FFFF);
    dp(0, 2'd1, 32'hE043_5004);
    dp(1, 2'd0, 32'hE284_6001);
    dp(1, 2'd0, 32'hE283_7001);
    str(32'hE580_5000);
    str(32'hE580_6000);
    str(32'hE580_7000);
    dp(1, 2'd0, 32'hE284_8003);
    str(32'hE580_8000);
    rst_mid(32'hE283_9005);
    str(32'hE580_9000);
    for (int i = 0; i < 120; i++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0, 1: dp(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), w);
        2: ldr(w, $urandom);
        3: begin
          w[15:12] = 4'($urandom_range(0, 14));
          str(w);
        end
        default: br(w);
      endcase
    end
    done = 1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
